uart_rx_sequencer: RTL

- Control and buffer stage for the UART receive path.
- Watches the synchronized serial line and detects and validates the start bit.
- Generates the one-cycle `shift_enable` strobes that clock the data bits into the serial-to-parallel shift register.
- Consumes that register's parallel word after the stop bit, then latches it into a holding buffer with ready, framing-error and overrun flags for the host side.

---
 rtl/uart_rx_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_sequencer.sv
// rtl/uart_rx_sequencer.sv - UART receive sequencer: start detect, shift strobes, holding buffer
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   serial_in      synchronized serial line (idle high), also feeds the shift register
//   parallel_in    shift register word, [0] = first received bit
//   data_read      host acknowledge, clears data_ready and overrun_error
//   shift_enable   one-cycle strobe clocking a data bit into the shift register
//   rx_data        holding buffer
//   data_ready     rx_data holds an unread word
//   framing_error  last frame ended with a low stop bit
//   overrun_error  an unread word was overwritten

module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BITS     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic [NUM_BITS-1:0] parallel_in,
    input  logic                data_read,
    output logic                shift_enable,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                framing_error,
    output logic                overrun_error
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(NUM_BITS + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_LOAD
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   bit_tmr;
    logic [CNT_W-1:0]   bit_cnt;
    logic               prev_serial;
    logic               stop_bit;
    logic               start_edge;

    assign start_edge = prev_serial && !serial_in;

    // Decoded from state and timer so the strobe lands in the same cycle the
    // timer reaches mid-bit; it can never appear outside DATA.
    assign shift_enable = (state == S_DATA) && (bit_tmr == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            bit_tmr       <= '0;
            bit_cnt       <= '0;
            prev_serial   <= 1'b1;
            stop_bit      <= 1'b1;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            prev_serial <= serial_in;

            // Host acknowledge; a load in the same cycle overrides below.
            if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state   <= S_START;
                        bit_tmr <= '0;
                    end
                end

                S_START: begin
                    if (bit_tmr == TMR_HALF) begin
                        if (!serial_in) begin
                            framing_error <= 1'b0;
                            state         <= S_DATA;
                            bit_tmr       <= '0;
                            bit_cnt       <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_tmr == TMR_LAST) begin
                        bit_tmr <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_LAST) begin
                            state <= S_STOP;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                S_STOP: begin
                    if (bit_tmr == TMR_LAST) begin
                        stop_bit <= serial_in;
                        bit_tmr  <= '0;
                        state    <= S_LOAD;
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                S_LOAD: begin
                    if (stop_bit) begin
                        rx_data       <= parallel_in;
                        data_ready    <= 1'b1;
                        overrun_error <= data_ready && !data_read;
                    end else begin
                        framing_error <= 1'b1;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
